i2s_rx_frontend: RTL and testbench
==================================

// Module: i2s_rx_frontend
// PURPOSE
//  Upstream feeder for the biquad IIR stage: deserialises a Philips-I2S stereo stream (external SCK/WS/SD)
//  into parallel Q1.15 left/right words in the clk domain. Presents one stereo frame per valid/ready
//  transfer; the filter chain samples sample_left/right as latest_sample. Single clk, clk >= 4x SCK.
// PARAMETERS
//  DATA_W       16  output word width (Q1.15 when 16); captured MSB-first from each slot
//  SYNC_STAGES  2   flops per pin synchroniser (min 2)
// PORTS
//  clk           in   1       system clock; all logic on rising edge
//  reset         in   1       asynchronous, active-high; clears all state
//  i2s_sck       in   1       I2S bit clock (async to clk)
//  i2s_ws        in   1       word select: 0 = left, 1 = right (async)
//  i2s_sd        in   1       serial data, MSB first (async)
//  sample_ready  in   1       downstream accepts frame when high with sample_valid
//  clr_flags     in   1       synchronous clear of overrun/short_word
//  sample_left   out  DATA_W  signed left word of last frame
//  sample_right  out  DATA_W  signed right word of last frame
//  sample_valid  out  1       frame available; held until accepted
//  overrun       out  1       sticky: frame replaced while not accepted
//  short_word    out  1       sticky: a slot had < DATA_W bits
// BEHAVIOUR
//  - Reset: all outputs 0, FSM = HUNT, bit counter 0, shift reg 0, ws_q 0.
//  - Pins pass SYNC_STAGES flops; SCK rising edge detected from synced sck vs. its last value (1-clk strobe).
//  - On each SCK-rise strobe: sample sd and ws. Bit goes into shift reg only if bit_cnt < DATA_W; bit_cnt
//    saturates at DATA_W. Extra bits beyond DATA_W are discarded (truncation).
//  - WS change (ws != ws_q) at a strobe marks that bit as the LSB of the word of channel ws_q (I2S 1-bit delay):
//    shift it in (if room), left-justify word (missing LSBs = 0, set short_word if bits < DATA_W),
//    latch to channel ws_q holding reg, reset bit_cnt, ws_q <= ws.
//  - FSM: HUNT -> (first WS change, any direction) discard word -> ws new ? RX_RIGHT : RX_LEFT.
//    RX_LEFT -> left word latched -> RX_RIGHT. RX_RIGHT -> right word latched -> frame emit if a left word
//    was latched since last emit -> RX_LEFT. Right word without a preceding left word is dropped.
//  - Emit: sample_left/right/valid registered together; valid rises exactly 4 clk after the SCK rising edge at
//    the pins carrying the right LSB (SYNC_STAGES=2). Latency fixed; no jitter vs. clk phase beyond 1 clk sync.
//  - Handshake: valid stays high, data stable, until valid&&ready at a clk edge; valid drops next cycle unless
//    a new frame emits in that same cycle (then valid stays high with new data; no overrun).
//  - Emit while valid && !ready: data replaced, valid stays high, overrun <= 1.
//  - clr_flags clears flags unless a flag event occurs same cycle (event wins).
//  - No SCK edges: outputs hold indefinitely. Async reset mid-frame: partial words discarded, back to HUNT.
// CONFIGURATION
//  - I2S_RX_MONO_MIX_EN defined: extra output sample_mono [DATA_W] = (left + right) >>> 1, sum computed at
//    DATA_W+1 bits (no overflow), arithmetic shift (floor), registered with and qualified by sample_valid.
//  - Not defined: port and adder absent; all other behaviour identical.
// STRUCTURE
//  - i2s_rx_pkg: fsm enum (HUNT, RX_LEFT, RX_RIGHT), DATA_W default constant, bit counter width via $clog2.
//  - Sub-module i2s_rx_sync: SYNC_STAGES synchroniser for sck/ws/sd plus SCK rising-edge strobe.
// TESTING  (clk = 8x SCK, 16-bit slots unless stated; ready = 1 unless stated)
//  - Reset held 4 clk -> all outputs 0; no valid before first full frame after HUNT.
//  - Frames L=0x1234, R=0xEDCB -> valid 1-clk pulse, left=0x1234, right=-4661; latency exactly 4 clk.
//  - 32-bit slots, L = 0x7FFF then 16 ones -> left=0x7FFF (truncated), short_word=0.
//  - 12-bit slots L=0xABC -> left=0xABC0 zero-padded, short_word=1; clr_flags -> 0.
//  - ready=0 over two frames (0x0001/0x0002 then 0x0003/0x0004) -> valid held, data 3/4, overrun=1.
//  - Reset mid-right-slot -> no emit of partial frame; next complete L/R frame emitted. MONO: L=100,R=-301 -> -101.

Source files
------------

// File: rtl/i2s_rx_pkg.sv
// i2s_rx_pkg: shared width defaults, FSM encoding and counter sizing for the I2S receive front end.
package i2s_rx_pkg;
    localparam int DATA_W_DEF = 16;
    typedef logic [1:0] state_t;
    localparam state_t HUNT     = 2'd0;
    localparam state_t RX_LEFT  = 2'd1;
    localparam state_t RX_RIGHT = 2'd2;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/i2s_rx_frontend_if.sv
// i2s_rx_frontend_if: stereo frame valid/ready bus toward the filter chain.
// I2S_RX_MONO_MIX_EN adds the registered mono mix word.
interface i2s_rx_frontend_if #(parameter int DATA_W = 16);
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;
`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_W-1:0] sample_mono;
    modport master(output sample_left, sample_right, sample_valid, sample_mono, input sample_ready);
    modport slave(input sample_left, sample_right, sample_valid, sample_mono, output sample_ready);
`else
    modport master(output sample_left, sample_right, sample_valid, input sample_ready);
    modport slave(input sample_left, sample_right, sample_valid, output sample_ready);
`endif
endinterface

// File: rtl/i2s_rx_sync.sv
// i2s_rx_sync: pin synchronisers for sck/ws/sd plus a registered SCK rising-edge strobe.
// ws_o/sd_o are registered alongside the strobe so all three describe the same pin sample.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_i,
    input  logic ws_i,
    input  logic sd_i,
    output logic rise_o,
    output logic ws_o,
    output logic sd_o
);
    logic [SYNC_STAGES-1:0] sck_q, ws_q, sd_q;
    logic                   sck_last_q, rise_q, ws_r_q, sd_r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q      <= '0;
            ws_q       <= '0;
            sd_q       <= '0;
            sck_last_q <= 1'b0;
            rise_q     <= 1'b0;
            ws_r_q     <= 1'b0;
            sd_r_q     <= 1'b0;
        end else begin
            sck_q      <= {sck_q[SYNC_STAGES-2:0], sck_i};
            ws_q       <= {ws_q[SYNC_STAGES-2:0], ws_i};
            sd_q       <= {sd_q[SYNC_STAGES-2:0], sd_i};
            sck_last_q <= sck_q[SYNC_STAGES-1];
            rise_q     <= sck_q[SYNC_STAGES-1] & ~sck_last_q;
            ws_r_q     <= ws_q[SYNC_STAGES-1];
            sd_r_q     <= sd_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = rise_q;
    assign ws_o   = ws_r_q;
    assign sd_o   = sd_r_q;
endmodule

// File: rtl/i2s_rx_frontend.sv
// i2s_rx_frontend: Philips-I2S deserialiser presenting left/right frames on a valid/ready bus.
// I2S_RX_MONO_MIX_EN adds sample_mono = floor((left + right) / 2).
module i2s_rx_frontend
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i2s_sck,
    input  logic i2s_ws,
    input  logic i2s_sd,
    input  logic clr_flags,
    i2s_rx_frontend_if.master smp,
    output logic overrun,
    output logic short_word
);
    localparam int CW = cnt_w(DATA_W);

    logic              rise, ws, sd;
    state_t            st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_in;
    logic [DATA_W-1:0] sh_q, sh_d, sh_in, word;
    logic [DATA_W-1:0] left_q, left_d, out_l_q, out_l_d, out_r_q, out_r_d;
    logic              ws_q, ws_d, have_left_q, have_left_d;
    logic              vld_q, vld_d, ovr_q, ovr_d, shw_q, shw_d;
    logic              room, end_w, latch_l, emit, short_ev;

    i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .sck_i (i2s_sck),
        .ws_i  (i2s_ws),
        .sd_i  (i2s_sd),
        .rise_o(rise),
        .ws_o  (ws),
        .sd_o  (sd)
    );

    // A WS change marks the current bit as the LSB of the ws_q channel's word (one-bit I2S delay).
    always_comb begin
        room        = cnt_q < CW'(DATA_W);
        sh_in       = room ? {sh_q[DATA_W-2:0], sd} : sh_q;
        cnt_in      = room ? cnt_q + CW'(1) : cnt_q;
        word        = sh_in << (DATA_W - int'(cnt_in));
        end_w       = rise && (ws != ws_q);
        latch_l     = end_w && (st_q == RX_LEFT);
        emit        = end_w && (st_q == RX_RIGHT) && have_left_q;
        short_ev    = end_w && (st_q != HUNT) && (cnt_in < CW'(DATA_W));
        st_d        = end_w ? (ws ? RX_RIGHT : RX_LEFT) : st_q;
        cnt_d       = end_w ? '0 : (rise ? cnt_in : cnt_q);
        sh_d        = end_w ? '0 : (rise ? sh_in : sh_q);
        ws_d        = rise ? ws : ws_q;
        left_d      = latch_l ? word : left_q;
        have_left_d = latch_l ? 1'b1 : ((end_w && st_q == RX_RIGHT) ? 1'b0 : have_left_q);
        out_l_d     = emit ? left_q : out_l_q;
        out_r_d     = emit ? word : out_r_q;
        vld_d       = emit | (vld_q & ~smp.sample_ready);
        ovr_d       = (emit & vld_q & ~smp.sample_ready) | (ovr_q & ~clr_flags);
        shw_d       = short_ev | (shw_q & ~clr_flags);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q        <= HUNT;
            cnt_q       <= '0;
            sh_q        <= '0;
            ws_q        <= 1'b0;
            left_q      <= '0;
            have_left_q <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            vld_q       <= 1'b0;
            ovr_q       <= 1'b0;
            shw_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            ws_q        <= ws_d;
            left_q      <= left_d;
            have_left_q <= have_left_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            vld_q       <= vld_d;
            ovr_q       <= ovr_d;
            shw_q       <= shw_d;
        end
    end

    assign smp.sample_left  = out_l_q;
    assign smp.sample_right = out_r_q;
    assign smp.sample_valid = vld_q;
    assign overrun          = ovr_q;
    assign short_word       = shw_q;

`ifdef I2S_RX_MONO_MIX_EN
    logic [DATA_W:0]   mix;
    logic [DATA_W-1:0] mono_q, mono_d;

    // One guard bit keeps the sum exact; dropping its LSB is an arithmetic (floor) halving.
    always_comb begin
        mix    = {left_q[DATA_W-1], left_q} + {word[DATA_W-1], word};
        mono_d = emit ? mix[DATA_W:1] : mono_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mono_q <= '0;
        else       mono_q <= mono_d;
    end

    assign smp.sample_mono = mono_q;
`endif
endmodule

// File: tb/tb_i2s_rx_frontend.sv
// tb_i2s_rx_frontend: scoreboard bench driving I2S frames at clk = 8x SCK.
// Define I2S_RX_MONO_MIX_EN to also check the mono mix output.
module tb_i2s_rx_frontend;
    logic clk = 1'b0, reset = 1'b1, i2s_sck = 1'b0, i2s_ws = 1'b0, i2s_sd = 1'b0, clr_flags = 1'b0;
    logic overrun, short_word;
    int   cyc = 0, n_cmp = 0, n_err = 0, last_rise = 0, lsb_cyc = 0;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [15:0] m;
        int          c;
    } frame_t;

    frame_t exp_q[$];
    frame_t obs_q[$];

    i2s_rx_frontend_if #(.DATA_W(16)) smp();

    i2s_rx_frontend dut (
        .clk       (clk),
        .reset     (reset),
        .i2s_sck   (i2s_sck),
        .i2s_ws    (i2s_ws),
        .i2s_sd    (i2s_sd),
        .clr_flags (clr_flags),
        .smp       (smp),
        .overrun   (overrun),
        .short_word(short_word)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (smp.sample_valid && smp.sample_ready) begin
`ifdef I2S_RX_MONO_MIX_EN
            obs_q.push_back('{smp.sample_left, smp.sample_right, smp.sample_mono, cyc});
`else
            obs_q.push_back('{smp.sample_left, smp.sample_right, 16'h0, cyc});
`endif
        end
    end

    task automatic bit_out(input logic w, input logic d);
        @(negedge clk);
        i2s_sck = 1'b0;
        i2s_ws  = w;
        i2s_sd  = d;
        repeat (4) @(negedge clk);
        i2s_sck   = 1'b1;
        last_rise = cyc;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_slot(input logic ch, input logic [31:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) bit_out(i == 0 ? ~ch : ch, data[i]);
    endtask

    task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
        send_slot(1'b0, l, n);
        send_slot(1'b1, r, n);
        lsb_cyc = last_rise;
    endtask

    task automatic wait_obs(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (obs_q.size() != 0) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (smp.sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", smp.sample_valid); end
        n_cmp++; if (smp.sample_left !== 16'h0) begin n_err++; $display("FAIL rst_left got %h exp 0000", smp.sample_left); end
        n_cmp++; if (smp.sample_right !== 16'h0) begin n_err++; $display("FAIL rst_right got %h exp 0000", smp.sample_right); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun got %b exp 0", overrun); end
        n_cmp++; if (short_word !== 1'b0) begin n_err++; $display("FAIL rst_short got %b exp 0", short_word); end
        reset = 1'b0;
        send_frame(32'h5A5A, 32'hA5A5, 16);
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL hunt_no_emit got %0d frames exp 0", obs_q.size()); end
        n_cmp++; if (smp.sample_valid !== 1'b0) begin n_err++; $display("FAIL hunt_valid got %b exp 0", smp.sample_valid); end
    endtask

    task automatic test_basic();
        frame_t e, f;
        bit ok;
        exp_q.push_back('{16'h1234, 16'hEDCB, 16'h0, 0});
        send_frame(32'h1234, 32'hEDCB, 16);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL basic_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.l !== e.l) begin n_err++; $display("FAIL basic_left got %h exp %h", f.l, e.l); end
            n_cmp++; if ($signed(f.r) !== -16'sd4661) begin n_err++; $display("FAIL basic_right got %0d exp -4661", $signed(f.r)); end
            n_cmp++; if (f.c - lsb_cyc !== 4) begin n_err++; $display("FAIL basic_latency got %0d exp 4", f.c - lsb_cyc); end
            @(negedge clk);
            n_cmp++; if (smp.sample_valid !== 1'b0) begin n_err++; $display("FAIL basic_pulse got valid %b exp 0", smp.sample_valid); end
        end
    endtask

    task automatic test_truncate();
        frame_t e, f;
        bit ok;
        exp_q.push_back('{16'h7FFF, 16'h5555, 16'h0, 0});
        send_frame(32'h7FFF_FFFF, 32'h5555_0000, 32);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL trunc_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.l !== e.l) begin n_err++; $display("FAIL trunc_left got %h exp %h", f.l, e.l); end
            n_cmp++; if (f.r !== e.r) begin n_err++; $display("FAIL trunc_right got %h exp %h", f.r, e.r); end
            n_cmp++; if (short_word !== 1'b0) begin n_err++; $display("FAIL trunc_short got %b exp 0", short_word); end
        end
    endtask

    task automatic test_short_word();
        frame_t e, f;
        bit ok;
        exp_q.push_back('{16'hABC0, 16'h1230, 16'h0, 0});
        send_frame(32'hABC, 32'h123, 12);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL short_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.l !== e.l) begin n_err++; $display("FAIL short_left got %h exp %h", f.l, e.l); end
            n_cmp++; if (f.r !== e.r) begin n_err++; $display("FAIL short_right got %h exp %h", f.r, e.r); end
            n_cmp++; if (short_word !== 1'b1) begin n_err++; $display("FAIL short_flag got %b exp 1", short_word); end
        end
        pulse_clr();
        n_cmp++; if (short_word !== 1'b0) begin n_err++; $display("FAIL short_clr got %b exp 0", short_word); end
    endtask

    task automatic test_overrun();
        frame_t e, f;
        bit ok;
        @(posedge clk); #2 smp.sample_ready = 1'b0;
        send_frame(32'h0001, 32'h0002, 16);
        exp_q.push_back('{16'h0003, 16'h0004, 16'h0, 0});
        send_frame(32'h0003, 32'h0004, 16);
        repeat (6) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL ovr_no_xfer got %0d frames exp 0", obs_q.size()); end
        n_cmp++; if (smp.sample_valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid got %b exp 1", smp.sample_valid); end
        n_cmp++; if (smp.sample_left !== 16'h0003) begin n_err++; $display("FAIL ovr_left got %h exp 0003", smp.sample_left); end
        n_cmp++; if (smp.sample_right !== 16'h0004) begin n_err++; $display("FAIL ovr_right got %h exp 0004", smp.sample_right); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_flag got %b exp 1", overrun); end
        @(posedge clk); #2 smp.sample_ready = 1'b1;
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL ovr_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.l !== e.l || f.r !== e.r) begin n_err++; $display("FAIL ovr_data got %h/%h exp %h/%h", f.l, f.r, e.l, e.r); end
        end
        pulse_clr();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr got %b exp 0", overrun); end
        n_cmp++; if (smp.sample_valid !== 1'b0) begin n_err++; $display("FAIL ovr_drop got valid %b exp 0", smp.sample_valid); end
    endtask

    task automatic test_reset_mid();
        frame_t e, f;
        bit ok;
        logic [15:0] rw;
        rw = 16'h2222;
        send_slot(1'b0, 32'h1111, 16);
        for (int i = 15; i >= 8; i--) bit_out(1'b1, rw[i]);
        @(negedge clk);
        i2s_sck = 1'b0;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (smp.sample_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid got %b exp 0", smp.sample_valid); end
        for (int i = 7; i >= 0; i--) bit_out(i != 0, rw[i]);
        repeat (8) @(negedge clk);
        n_cmp++; if (obs_q.size() != 0) begin n_err++; $display("FAIL mid_partial got %0d frames exp 0", obs_q.size()); end
        exp_q.push_back('{16'h0A0B, 16'h0C0D, 16'h0, 0});
        send_frame(32'h0A0B, 32'h0C0D, 16);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL mid_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.l !== e.l) begin n_err++; $display("FAIL mid_left got %h exp %h", f.l, e.l); end
            n_cmp++; if (f.r !== e.r) begin n_err++; $display("FAIL mid_right got %h exp %h", f.r, e.r); end
        end
    endtask

`ifdef I2S_RX_MONO_MIX_EN
    task automatic test_mono();
        frame_t e, f;
        bit ok;
        exp_q.push_back('{16'd100, 16'hFED3, 16'hFF9B, 0});
        send_frame(32'd100, 32'hFED3, 16);
        wait_obs(ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL mono_wait got no frame exp one within 100 clk"); end
        else begin
            f = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++; if (f.m !== e.m) begin n_err++; $display("FAIL mono_mix got %0d exp %0d", $signed(f.m), $signed(e.m)); end
        end
    endtask
`endif

    initial begin
        smp.sample_ready = 1'b1;
        test_reset();
        test_basic();
        test_truncate();
        test_short_word();
        test_overrun();
        test_reset_mid();
`ifdef I2S_RX_MONO_MIX_EN
        test_mono();
`endif
        n_cmp++; if (exp_q.size() != 0 || obs_q.size() != 0) begin n_err++; $display("FAIL leftover got exp %0d obs %0d exp 0/0", exp_q.size(), obs_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
